// File: rtl/pcie_tbl_pkg.sv
// Shared types and constants for the multi-channel table RAM read engine.
package pcie_tbl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  // Wide enough for FIFO count plus every read in flight at the largest RAM_LAT.
  localparam int CNT_W = 4;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Two slots beyond the RAM latency keep bursts gapless once a stall releases.
  function automatic int fifo_depth(input int lat);
    return lat + 2;
  endfunction

endpackage

// File: rtl/pcie_tbl_rd_fifo.sv
// Sync FIFO with registered output stage and occupancy count; write-to-output 1 cycle.
// Output holds while i_rd_rdy=0; caller must never write when full.
module pcie_tbl_rd_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_vld,
  input  logic [W-1:0]     i_wr_dat,
  input  logic             i_rd_rdy,
  output logic             o_rd_vld,
  output logic [W-1:0]     o_rd_dat,
  output logic [CNT_W-1:0] o_cnt
);
  localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_scnt;
  logic             r_vld;
  logic [W-1:0]     r_dat;
  logic             w_load, w_st_rd, w_st_wr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Output stage refills when empty or being consumed; storage is bypassed when empty.
  assign w_load  = !r_vld || i_rd_rdy;
  assign w_st_rd = w_load && (r_scnt != '0);
  assign w_st_wr = i_wr_vld && !(w_load && (r_scnt == '0));

  always_ff @(posedge clk) begin
    if (w_st_wr) r_mem[r_wptr] <= i_wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_scnt <= '0;
      r_vld  <= 1'b0;
      r_dat  <= '0;
    end else begin
      if (w_st_wr) r_wptr <= ptr_inc(r_wptr);
      if (w_st_rd) r_rptr <= ptr_inc(r_rptr);
      r_scnt <= r_scnt + CNT_W'(w_st_wr) - CNT_W'(w_st_rd);
      if (w_load) begin
        if (w_st_rd) begin
          r_vld <= 1'b1;
          r_dat <= r_mem[r_rptr];
        end else if (i_wr_vld) begin
          r_vld <= 1'b1;
          r_dat <= i_wr_dat;
        end else begin
          r_vld <= 1'b0;
        end
      end
    end
  end

  assign o_rd_vld = r_vld;
  assign o_rd_dat = r_dat;
  assign o_cnt    = r_scnt + CNT_W'(r_vld);

endmodule

// File: rtl/pcie_tbl_rd.sv
// Multi-channel burst reader from table RAMs to the PCIe DMA read port; first beat 2+RAM_LAT cycles after request.
// Credit-limited issue, stall holds the output beat; PCIE_TBL_RD_SWAP_EN byte-reverses the data.
module pcie_tbl_rd
  import pcie_tbl_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int RAM_AW  = 10,
  parameter int NUM_CH  = 4,
  parameter int RAM_LAT = 2,
  parameter int LEN_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dma_raddr_en,
  input  logic [31:0]              dma_raddr,
  input  logic [LEN_W-1:0]         dma_rlen,
  output logic [DATA_W-1:0]        dma_rdata,
  output logic                     dma_rdata_rdy,
  output logic                     dma_rdata_last,
  input  logic                     dma_rdata_stall,
  output logic                     dma_rdata_busy,
  output logic                     dma_req_drop,
  output logic                     dma_rd_err,
  output logic                     ott_ram_rd_en,
  output logic [RAM_AW-1:0]        ott_ram_addr,
  input  logic [NUM_CH*DATA_W-1:0] ott_ram_data
);
  localparam int CH_W       = ch_w(NUM_CH);
  localparam int FIFO_DEPTH = fifo_depth(RAM_LAT);
  localparam int CHF_W      = 29 - RAM_AW;

  rd_state_t         r_state;
  logic              r_busy, r_rd_en, r_drop, r_err;
  logic [RAM_AW-1:0] r_addr;
  logic [LEN_W-1:0]  r_pend;
  logic [CH_W-1:0]   r_ch;
  logic [RAM_LAT-1:0] r_vpipe, r_lpipe;

  logic [RAM_AW-1:0] w_word;
  logic [CHF_W-1:0]  w_ch_full;
  logic              w_ch_bad, w_last_iss, w_pop, w_credit, w_unused;
  logic [CNT_W-1:0]  w_fifo_cnt, w_vcnt, w_used;
  logic [DATA_W-1:0] w_sel_dat;
  logic [DATA_W:0]   w_out_dat;
  logic              w_out_vld, w_out_last;

  // Every address bit above the word field is treated as channel, so out-of-range values are caught.
  assign w_word    = dma_raddr[RAM_AW+2:3];
  assign w_ch_full = dma_raddr[31:RAM_AW+3];
  assign w_ch_bad  = (w_ch_full >= CHF_W'(NUM_CH));
  assign w_unused  = ^dma_raddr[2:0];

  assign w_last_iss = r_rd_en && (r_pend == '0);
  assign w_pop      = w_out_vld && !dma_rdata_stall;
  assign w_out_last = w_out_dat[DATA_W];

  always_comb begin
    w_vcnt = '0;
    for (int i = 0; i < RAM_LAT; i++) w_vcnt = w_vcnt + CNT_W'(r_vpipe[i]);
  end

  // Slots committed after this edge must leave room for one more read.
  assign w_used   = w_fifo_cnt + w_vcnt + CNT_W'(r_rd_en);
  assign w_credit = w_used < (CNT_W'(FIFO_DEPTH) + CNT_W'(w_pop));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_rd_en <= 1'b0;
      r_drop  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_pend  <= '0;
      r_ch    <= '0;
    end else begin
      r_drop <= dma_raddr_en && r_busy;
      case (r_state)
        IDLE: begin
          if (dma_raddr_en) begin
            r_state <= ISSUE;
            r_busy  <= 1'b1;
            r_rd_en <= 1'b1;
            r_addr  <= w_word;
            r_pend  <= dma_rlen - LEN_W'(1);
            r_ch    <= w_ch_full[CH_W-1:0];
            r_err   <= w_ch_bad;
          end
        end
        ISSUE: begin
          if (r_pend == '0) begin
            r_rd_en <= 1'b0;
            r_state <= DRAIN;
          end else if (w_credit) begin
            r_rd_en <= 1'b1;
            r_addr  <= r_addr + 1'b1;
            r_pend  <= r_pend - 1'b1;
          end else begin
            r_rd_en <= 1'b0;
          end
        end
        DRAIN: begin
          if (w_pop && w_out_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vpipe <= '0;
      r_lpipe <= '0;
    end else begin
      r_vpipe[0] <= r_rd_en;
      r_lpipe[0] <= w_last_iss;
      for (int i = 1; i < RAM_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        r_lpipe[i] <= r_lpipe[i-1];
      end
    end
  end

  always_comb begin
    w_sel_dat = '0;
    if (!r_err) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (r_ch == CH_W'(c)) w_sel_dat = ott_ram_data[c*DATA_W +: DATA_W];
      end
    end
  end

  pcie_tbl_rd_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .i_wr_vld (r_vpipe[RAM_LAT-1]),
    .i_wr_dat ({r_lpipe[RAM_LAT-1], w_sel_dat}),
    .i_rd_rdy (!dma_rdata_stall),
    .o_rd_vld (w_out_vld),
    .o_rd_dat (w_out_dat),
    .o_cnt    (w_fifo_cnt)
  );

`ifdef PCIE_TBL_RD_SWAP_EN
  always_comb begin
    dma_rdata = '0;
    for (int b = 0; b < DATA_W/8; b++) dma_rdata[8*b +: 8] = w_out_dat[DATA_W-8-8*b +: 8];
  end
`else
  assign dma_rdata = w_out_dat[DATA_W-1:0];
`endif

  assign dma_rdata_rdy  = w_out_vld;
  assign dma_rdata_last = w_out_vld && w_out_last;
  assign dma_rdata_busy = r_busy;
  assign dma_req_drop   = r_drop;
  assign dma_rd_err     = r_err;
  assign ott_ram_rd_en  = r_rd_en;
  assign ott_ram_addr   = r_addr;

endmodule

// File: tb/tb_pcie_tbl_rd.sv
// Directed bench for pcie_tbl_rd: burst table plus reset-mid-burst sequence.
module tb_pcie_tbl_rd;
  localparam int DATA_W  = 64;
  localparam int RAM_AW  = 10;
  localparam int NUM_CH  = 4;
  localparam int RAM_LAT = 2;
  localparam int LEN_W   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     dma_raddr_en;
  logic [31:0]              dma_raddr;
  logic [LEN_W-1:0]         dma_rlen;
  logic [DATA_W-1:0]        dma_rdata;
  logic                     dma_rdata_rdy, dma_rdata_last, dma_rdata_stall;
  logic                     dma_rdata_busy, dma_req_drop, dma_rd_err;
  logic                     ott_ram_rd_en;
  logic [RAM_AW-1:0]        ott_ram_addr;
  logic [NUM_CH*DATA_W-1:0] ott_ram_data;

  int nvec = 0;
  int nbad = 0;

  pcie_tbl_rd #(
    .DATA_W(DATA_W), .RAM_AW(RAM_AW), .NUM_CH(NUM_CH), .RAM_LAT(RAM_LAT), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst),
    .dma_raddr_en(dma_raddr_en), .dma_raddr(dma_raddr), .dma_rlen(dma_rlen),
    .dma_rdata(dma_rdata), .dma_rdata_rdy(dma_rdata_rdy), .dma_rdata_last(dma_rdata_last),
    .dma_rdata_stall(dma_rdata_stall), .dma_rdata_busy(dma_rdata_busy),
    .dma_req_drop(dma_req_drop), .dma_rd_err(dma_rd_err),
    .ott_ram_rd_en(ott_ram_rd_en), .ott_ram_addr(ott_ram_addr), .ott_ram_data(ott_ram_data)
  );

  // Channel number in bits [63:48] lets each beat prove which RAM it came from.
  function automatic logic [63:0] ram_word(input int c, input logic [RAM_AW-1:0] a);
    if (c == 2 && a == 10'h155) return 64'h0102030405060708;
    return (64'(c) << 48) | 64'(a);
  endfunction

  function automatic logic [63:0] bswap(input logic [63:0] d);
    logic [63:0] r;
`ifdef PCIE_TBL_RD_SWAP_EN
    for (int b = 0; b < 8; b++) r[8*b +: 8] = d[56-8*b +: 8];
`else
    r = d;
`endif
    return r;
  endfunction

  logic [RAM_AW-1:0] p_addr [RAM_LAT];
  always @(posedge clk) begin
    p_addr[0] <= ott_ram_addr;
    for (int i = 1; i < RAM_LAT; i++) p_addr[i] <= p_addr[i-1];
  end
  always_comb begin
    ott_ram_data = '0;
    for (int c = 0; c < NUM_CH; c++) ott_ram_data[c*DATA_W +: DATA_W] = ram_word(c, p_addr[RAM_LAT-1]);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, dma_rdata, 64'd0);
    chk({tag, "_rdy"}, dma_rdata_rdy, 64'd0);
    chk({tag, "_last"}, dma_rdata_last, 64'd0);
    chk({tag, "_busy"}, dma_rdata_busy, 64'd0);
    chk({tag, "_drop"}, dma_req_drop, 64'd0);
    chk({tag, "_err"}, dma_rd_err, 64'd0);
    chk({tag, "_rd_en"}, ott_ram_rd_en, 64'd0);
    chk({tag, "_addr"}, ott_ram_addr, 64'd0);
  endtask

  typedef struct {
    logic [31:0]      addr;
    logic [LEN_W-1:0] len;
    int               nbeats;
    int               ch;
    logic [RAM_AW-1:0] word;
    bit               err;
    int               stall_beat;
    int               stall_k;
    int               drop_at;
  } vec_t;

  // Caller is at a negedge with busy=0; the request occupies cycle 0.
  task automatic run_burst(input vec_t v);
    int beat, stall_left, first_cyc, last_cyc;
    bit done;
    logic [RAM_AW-1:0] wa;
    logic [63:0] exp;
    dma_raddr = v.addr;
    dma_rlen = v.len;
    dma_raddr_en = 1'b1;
    dma_rdata_stall = 1'b0;
    beat = 0; stall_left = v.stall_k; first_cyc = -1; last_cyc = -1; done = 1'b0;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk);
      dma_raddr_en = 1'b0;
      if (v.drop_at != 0 && cyc == v.drop_at) begin
        dma_raddr_en = 1'b1;
        dma_raddr = 32'h0000_1FF0;
      end
      if (cyc == 1) begin
        chk("busy_start", dma_rdata_busy, 64'd1);
        chk("rd_en_first", ott_ram_rd_en, 64'd1);
        chk("addr_first", ott_ram_addr, 64'(v.word));
        chk("rd_err", dma_rd_err, 64'(v.err));
      end
      if (v.drop_at != 0) chk("req_drop", dma_req_drop, 64'(cyc == v.drop_at + 1));
      if (last_cyc >= 0) begin
        chk("busy_fall", dma_rdata_busy, 64'd0);
        chk("last_cycle", 64'(last_cyc), 64'(2 + RAM_LAT + v.nbeats - 1 + v.stall_k));
        chk("beat_count", 64'(beat), 64'(v.nbeats));
        done = 1'b1;
      end else if (dma_rdata_rdy) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          chk("first_rdy_cycle", 64'(cyc), 64'(2 + RAM_LAT));
        end
        wa = v.word + RAM_AW'(beat);
        exp = v.err ? 64'd0 : bswap(ram_word(v.ch, wa));
        chk("beat_data", dma_rdata, exp);
        chk("beat_last", dma_rdata_last, 64'(beat == v.nbeats - 1));
        if (beat == v.stall_beat && stall_left > 0) begin
          dma_rdata_stall = 1'b1;
          stall_left--;
        end else begin
          dma_rdata_stall = 1'b0;
          if (beat == v.nbeats - 1) last_cyc = cyc;
          beat++;
        end
      end else begin
        dma_rdata_stall = 1'b0;
      end
    end
    dma_rdata_stall = 1'b0;
    if (!done) begin
      nvec++;
      nbad++;
      $display("FAIL burst_timeout: addr %h beats seen %0d of %0d", v.addr, beat, v.nbeats);
    end
  endtask

  vec_t vt[7];
  int ntx;

  initial begin
    vt[0] = '{addr:32'h0000_2080, len:5'd4, nbeats:4,  ch:1, word:10'h010, err:1'b0, stall_beat:-1, stall_k:0, drop_at:0};
    vt[1] = '{addr:32'h0000_1FF0, len:5'd4, nbeats:4,  ch:0, word:10'h3FE, err:1'b0, stall_beat:-1, stall_k:0, drop_at:0};
    vt[2] = '{addr:32'h0000_6800, len:5'd8, nbeats:8,  ch:3, word:10'h100, err:1'b0, stall_beat:1,  stall_k:3, drop_at:0};
    vt[3] = '{addr:32'h0000_2080, len:5'd4, nbeats:4,  ch:1, word:10'h010, err:1'b0, stall_beat:-1, stall_k:0, drop_at:2};
    vt[4] = '{addr:32'h0000_A100, len:5'd2, nbeats:2,  ch:5, word:10'h020, err:1'b1, stall_beat:-1, stall_k:0, drop_at:0};
    vt[5] = '{addr:32'h0000_4AA8, len:5'd1, nbeats:1,  ch:2, word:10'h155, err:1'b0, stall_beat:-1, stall_k:0, drop_at:0};
    vt[6] = '{addr:32'h0000_4000, len:5'd0, nbeats:32, ch:2, word:10'h000, err:1'b0, stall_beat:5,  stall_k:2, drop_at:0};

    rst = 1'b0;
    dma_raddr_en = 1'b0;
    dma_raddr = '0;
    dma_rlen = '0;
    dma_rdata_stall = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_burst(vt[i]);

    // Reset asserted after two beats of an 8-beat burst.
    dma_raddr = 32'h0000_2080;
    dma_rlen = 5'd8;
    dma_raddr_en = 1'b1;
    ntx = 0;
    for (int c = 1; c <= 40 && ntx < 2; c++) begin
      @(negedge clk);
      dma_raddr_en = 1'b0;
      if (dma_rdata_rdy) ntx++;
    end
    @(negedge clk);
    chk("midburst_beats_seen", 64'(ntx), 64'd2);
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("post_rst_rdy", dma_rdata_rdy, 64'd0);
      chk("post_rst_rd_en", ott_ram_rd_en, 64'd0);
    end
    run_burst(vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
